// File: rtl/mips_muldiv_pkg.sv
// Shared funct codes, FSM state encoding and default datapath width for the
// EX-stage multiply/divide unit.
package mips_muldiv_pkg;

  localparam int MD_XLEN = 32;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic is_mul_fn(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_MULTU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply (add-shift right) or restoring divide
// (shift left, trial subtract) datapath. Divide path exists only with MULDIV_DIV_EN.
module muldiv_step
  import mips_muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
`ifdef MULDIV_DIV_EN
  input  logic            div_i,
`endif
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] sh_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] sh_o
);

  logic [XLEN:0] sum;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0] trial;
  logic [XLEN:0] diff;
`endif

  always_comb begin
    // Multiply: the carry out of the add shifts into the top of acc.
    sum = {1'b0, acc_i} + (sh_i[0] ? {1'b0, opnd_i} : '0);
    {acc_o, sh_o} = {sum, sh_i[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    trial = {acc_i, sh_i[XLEN-1]};
    diff  = trial - {1'b0, opnd_i};
    if (div_i) begin
      if (!diff[XLEN]) begin
        acc_o = diff[XLEN-1:0];
        sh_o  = {sh_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = trial[XLEN-1:0];
        sh_o  = {sh_i[XLEN-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit with HI/LO, MFxx/MTxx support.
// Define MULDIV_DIV_EN to include the divider; otherwise DIV/DIVU are no-ops.
module ex_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            EX_Valid,
  input  logic [5:0]      EX_Opcode,
  input  logic [5:0]      EX_Funct,
  input  logic [XLEN-1:0] EX_RS_Data,
  input  logic [XLEN-1:0] EX_RT_Data,
  output logic            Stall,
  output logic            MF_Valid,
  output logic [XLEN-1:0] MF_Data,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);

  md_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] acc_q, sh_q, opnd_q, hi_q, lo_q;
  logic [XLEN-1:0] acc_d, sh_d;
  logic            neg_q;
`ifdef MULDIV_DIV_EN
  logic            rs_neg_q, div0_q;
  logic [XLEN-1:0] quo_fix, rem_fix;
`endif

  logic            rtype, is_div, start, sgn_op, last;
  logic [XLEN-1:0] rs_abs, rt_abs;
  logic [2*XLEN-1:0] prod, prod_fix;

  assign rtype = EX_Valid && (EX_Opcode == 6'h00);
`ifdef MULDIV_DIV_EN
  assign is_div = (EX_Funct == FN_DIV) || (EX_Funct == FN_DIVU);
`else
  assign is_div = 1'b0;
`endif
  assign start  = rtype && (is_mul_fn(EX_Funct) || is_div) && (state_q == ST_IDLE);
  assign sgn_op = (EX_Funct == FN_MULT) || (EX_Funct == FN_DIV);
  assign rs_abs = (sgn_op && EX_RS_Data[XLEN-1]) ? -EX_RS_Data : EX_RS_Data;
  assign rt_abs = (sgn_op && EX_RT_Data[XLEN-1]) ? -EX_RT_Data : EX_RT_Data;
  assign last   = (cnt_q == CNT_W'(XLEN-1));

  muldiv_step #(.XLEN(XLEN)) u_step (
`ifdef MULDIV_DIV_EN
    .div_i  (state_q == ST_DIV),
`endif
    .acc_i  (acc_q),
    .sh_i   (sh_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_d),
    .sh_o   (sh_d)
  );

  // Sign fix-up is applied to the final step's output so HI/LO land on DONE entry.
  assign prod     = {acc_d, sh_d};
  assign prod_fix = neg_q ? -prod : prod;
`ifdef MULDIV_DIV_EN
  assign quo_fix  = div0_q ? '1 : (neg_q ? -sh_d : sh_d);
  assign rem_fix  = rs_neg_q ? -acc_d : acc_d;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
      rs_neg_q <= 1'b0;
      div0_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= is_div ? ST_DIV : ST_MUL;
            cnt_q   <= '0;
            acc_q   <= '0;
            sh_q    <= is_div ? rs_abs : rt_abs;
            opnd_q  <= is_div ? rt_abs : rs_abs;
            neg_q   <= sgn_op && (EX_RS_Data[XLEN-1] ^ EX_RT_Data[XLEN-1]);
`ifdef MULDIV_DIV_EN
            rs_neg_q <= sgn_op && EX_RS_Data[XLEN-1];
            div0_q   <= (EX_RT_Data == '0);
`endif
          end else if (rtype && (EX_Funct == FN_MTHI)) begin
            hi_q <= EX_RS_Data;
          end else if (rtype && (EX_Funct == FN_MTLO)) begin
            lo_q <= EX_RS_Data;
          end
        end
        ST_MUL: begin
          acc_q <= acc_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state_q      <= ST_DONE;
            {hi_q, lo_q} <= prod_fix;
          end
        end
`ifdef MULDIV_DIV_EN
        ST_DIV: begin
          acc_q <= acc_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state_q <= ST_DONE;
            lo_q    <= quo_fix;
            hi_q    <= rem_fix;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Stall    = start || (state_q == ST_MUL) || (state_q == ST_DIV);
  assign MF_Valid = rtype && ((EX_Funct == FN_MFHI) || (EX_Funct == FN_MFLO));
  assign MF_Data  = (EX_Funct == FN_MFHI) ? hi_q : lo_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule
